// File: rtl/compressed_icache_controller.sv
// compressed_icache_controller
//   Instruction-fetch controller with two direct-mapped caches looked up in
//   parallel: a plain cache of 32-bit words and a compressed cache of
//   dictionary keys. On a miss in both, the word is fetched from memory. If
//   every field of the word is found in its dictionary, the word goes into
//   the compressed cache as a key. Otherwise it goes into the plain cache.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   proc_valid/proc_ready        core fetch handshake, proc_addr in, proc_rdata out
//   mem_req_valid/mem_req_ready  memory handshake, mem_req_addr out, mem_req_rdata in
//   dictN_write_enable/_val      dictionary load port; each dictionary has a
//                                write pointer that wraps
//   debug_*                      miss pulses, occupancies, field-lookup status,
//                                and the decompressed word

module compressed_icache_controller #(
    parameter int ICACHE_ENTRIES = 16,
    parameter int COMP_ENTRIES   = 32,
    parameter int F1_VAL_W       = 7,
    parameter int F2_VAL_W       = 10,
    parameter int F3_VAL_W       = 15,
    parameter int F1_KEY_W       = 3,
    parameter int F2_KEY_W       = 5,
    parameter int F3_KEY_W       = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                proc_valid,
    output logic                proc_ready,
    input  logic [31:0]         proc_addr,
    output logic [31:0]         proc_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_req_addr,
    input  logic [31:0]         mem_req_rdata,
    input  logic                dict1_write_enable,
    input  logic                dict2_write_enable,
    input  logic                dict3_write_enable,
    input  logic [F1_VAL_W-1:0] dict1_write_val,
    input  logic [F2_VAL_W-1:0] dict2_write_val,
    input  logic [F3_VAL_W-1:0] dict3_write_val,
    output logic                debug_icache_miss,
    output logic                debug_comp_cache_miss,
    output logic [31:0]         debug_icache_occupancy,
    output logic [31:0]         debug_comp_occupancy,
    output logic                debug_compressible,
    output logic                debug_field1_val_lookup_result,
    output logic                debug_field2_val_lookup_result,
    output logic                debug_field3_val_lookup_result,
    output logic                debug_compressible_instr,
    output logic [31:0]         debug_decompressed_instr
);

    localparam int IC_IDX_W = $clog2(ICACHE_ENTRIES);
    localparam int IC_TAG_W = 30 - IC_IDX_W;
    localparam int CC_IDX_W = $clog2(COMP_ENTRIES);
    localparam int CC_TAG_W = 30 - CC_IDX_W;
    localparam int KEY_W    = F1_KEY_W + F2_KEY_W + F3_KEY_W;
    localparam int D1_DEPTH = 1 << F1_KEY_W;
    localparam int D2_DEPTH = 1 << F2_KEY_W;
    localparam int D3_DEPTH = 1 << F3_KEY_W;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MISS_REQ  = 2'd1;
    localparam logic [1:0] MISS_WAIT = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    logic [1:0] state;

    // ---------------- dictionaries (contents never reset) ----------------
    logic [F1_VAL_W-1:0] dict1 [D1_DEPTH];
    logic [F2_VAL_W-1:0] dict2 [D2_DEPTH];
    logic [F3_VAL_W-1:0] dict3 [D3_DEPTH];
    logic [F1_KEY_W-1:0] dict1_ptr;
    logic [F2_KEY_W-1:0] dict2_ptr;
    logic [F3_KEY_W-1:0] dict3_ptr;

    // A write strobe takes priority over reset, so loading can proceed while
    // resetn is held low.
    always_ff @(posedge clk) begin
        if (dict1_write_enable) begin
            dict1[dict1_ptr] <= dict1_write_val;
            dict1_ptr        <= dict1_ptr + 1'b1;
        end else if (!resetn) begin
            dict1_ptr <= '0;
        end
        if (dict2_write_enable) begin
            dict2[dict2_ptr] <= dict2_write_val;
            dict2_ptr        <= dict2_ptr + 1'b1;
        end else if (!resetn) begin
            dict2_ptr <= '0;
        end
        if (dict3_write_enable) begin
            dict3[dict3_ptr] <= dict3_write_val;
            dict3_ptr        <= dict3_ptr + 1'b1;
        end else if (!resetn) begin
            dict3_ptr <= '0;
        end
    end

    // ---------------- compression of the memory word ----------------
    logic [F1_VAL_W-1:0] f1;
    logic [F2_VAL_W-1:0] f2;
    logic [F3_VAL_W-1:0] f3;
    logic [F1_KEY_W-1:0] k1;
    logic [F2_KEY_W-1:0] k2;
    logic [F3_KEY_W-1:0] k3;
    logic                f1_hit, f2_hit, f3_hit;

    assign f1 = mem_req_rdata[F1_VAL_W-1:0];
    assign f2 = mem_req_rdata[F1_VAL_W +: F2_VAL_W];
    assign f3 = mem_req_rdata[F1_VAL_W+F2_VAL_W +: F3_VAL_W];

    // The first match wins, so each key is the lowest matching index.
    always_comb begin
        f1_hit = 1'b0;
        k1     = '0;
        for (int unsigned i = 0; i < D1_DEPTH; i++) begin
            if (!f1_hit && dict1[i] == f1) begin
                f1_hit = 1'b1;
                k1     = F1_KEY_W'(i);
            end
        end
        f2_hit = 1'b0;
        k2     = '0;
        for (int unsigned i = 0; i < D2_DEPTH; i++) begin
            if (!f2_hit && dict2[i] == f2) begin
                f2_hit = 1'b1;
                k2     = F2_KEY_W'(i);
            end
        end
        f3_hit = 1'b0;
        k3     = '0;
        for (int unsigned i = 0; i < D3_DEPTH; i++) begin
            if (!f3_hit && dict3[i] == f3) begin
                f3_hit = 1'b1;
                k3     = F3_KEY_W'(i);
            end
        end
    end

    assign debug_field1_val_lookup_result = f1_hit;
    assign debug_field2_val_lookup_result = f2_hit;
    assign debug_field3_val_lookup_result = f3_hit;
    assign debug_compressible             = f1_hit & f2_hit & f3_hit;

    // ---------------- cache arrays ----------------
    logic [31:0]         ic_data [ICACHE_ENTRIES];
    logic [IC_TAG_W-1:0] ic_tag  [ICACHE_ENTRIES];
    logic [ICACHE_ENTRIES-1:0] ic_valid;
    logic [KEY_W-1:0]    cc_key  [COMP_ENTRIES];
    logic [CC_TAG_W-1:0] cc_tag  [COMP_ENTRIES];
    logic [COMP_ENTRIES-1:0]   cc_valid;

    logic [IC_IDX_W-1:0] ic_idx, ic_fill_idx;
    logic [CC_IDX_W-1:0] cc_idx, cc_fill_idx;
    logic                ic_hit, cc_hit, fill_en;
    logic [KEY_W-1:0]    cc_line;
    logic [31:0]         cc_word;

    assign ic_idx      = proc_addr[IC_IDX_W+1:2];
    assign cc_idx      = proc_addr[CC_IDX_W+1:2];
    assign ic_fill_idx = mem_req_addr[IC_IDX_W+1:2];
    assign cc_fill_idx = mem_req_addr[CC_IDX_W+1:2];

    assign ic_hit = ic_valid[ic_idx] && (ic_tag[ic_idx] == proc_addr[31:IC_IDX_W+2]);
    assign cc_hit = cc_valid[cc_idx] && (cc_tag[cc_idx] == proc_addr[31:CC_IDX_W+2]);

    assign cc_line = cc_key[cc_idx];
    assign cc_word = {dict3[cc_line[F1_KEY_W+F2_KEY_W +: F3_KEY_W]],
                      dict2[cc_line[F1_KEY_W +: F2_KEY_W]],
                      dict1[cc_line[F1_KEY_W-1:0]]};

    assign fill_en = resetn && mem_req_ready &&
                     (state == MISS_REQ || state == MISS_WAIT);

    always_ff @(posedge clk) begin
        if (fill_en) begin
            if (debug_compressible) begin
                cc_key[cc_fill_idx] <= {k3, k2, k1};
                cc_tag[cc_fill_idx] <= mem_req_addr[31:CC_IDX_W+2];
            end else begin
                ic_data[ic_fill_idx] <= mem_req_rdata;
                ic_tag[ic_fill_idx]  <= mem_req_addr[31:IC_IDX_W+2];
            end
        end
    end

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state                    <= IDLE;
            ic_valid                 <= '0;
            cc_valid                 <= '0;
            proc_ready               <= 1'b0;
            proc_rdata               <= '0;
            mem_req_valid            <= 1'b0;
            mem_req_addr             <= '0;
            debug_icache_miss        <= 1'b0;
            debug_comp_cache_miss    <= 1'b0;
            debug_compressible_instr <= 1'b0;
            debug_decompressed_instr <= '0;
        end else begin
            proc_ready            <= 1'b0;
            debug_icache_miss     <= 1'b0;
            debug_comp_cache_miss <= 1'b0;
            case (state)
                IDLE: begin
                    if (proc_valid) begin
                        if (cc_hit) begin
                            debug_decompressed_instr <= cc_word;
                        end
                        if (ic_hit) begin
                            proc_rdata               <= ic_data[ic_idx];
                            debug_compressible_instr <= 1'b0;
                            proc_ready               <= 1'b1;
                            state                    <= RESP;
                        end else if (cc_hit) begin
                            proc_rdata               <= cc_word;
                            debug_compressible_instr <= 1'b1;
                            proc_ready               <= 1'b1;
                            state                    <= RESP;
                        end else begin
                            // A hit in either cache serves the fetch, so the
                            // miss pulses fire only when the fetch goes to
                            // memory. Both pulse together in that case.
                            debug_icache_miss     <= 1'b1;
                            debug_comp_cache_miss <= 1'b1;
                            mem_req_valid         <= 1'b1;
                            mem_req_addr          <= proc_addr;
                            state                 <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ, MISS_WAIT: begin
                    if (mem_req_ready) begin
                        mem_req_valid            <= 1'b0;
                        proc_rdata               <= mem_req_rdata;
                        debug_compressible_instr <= 1'b0;
                        proc_ready               <= 1'b1;
                        state                    <= RESP;
                        if (debug_compressible) begin
                            cc_valid[cc_fill_idx] <= 1'b1;
                        end else begin
                            ic_valid[ic_fill_idx] <= 1'b1;
                        end
                    end else begin
                        state <= MISS_WAIT;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Occupancy is a population count of the valid bits, so it cannot exceed
    // the number of lines.
    always_comb begin
        debug_icache_occupancy = '0;
        for (int unsigned i = 0; i < ICACHE_ENTRIES; i++) begin
            debug_icache_occupancy = debug_icache_occupancy + 32'(ic_valid[i]);
        end
        debug_comp_occupancy = '0;
        for (int unsigned i = 0; i < COMP_ENTRIES; i++) begin
            debug_comp_occupancy = debug_comp_occupancy + 32'(cc_valid[i]);
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{proc_addr[1:0], mem_req_addr[1:0]};

endmodule

// File: tb/tb_compressed_icache_controller.sv
// Testbench for compressed_icache_controller.
// The bench holds its own memory image and dictionary contents. For every
// fetch it pushes the expected word to a queue and pops it when proc_ready
// fires.

module tb_compressed_icache_controller;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        proc_valid = 1'b0;
    logic        proc_ready;
    logic [31:0] proc_addr = '0;
    logic [31:0] proc_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_rdata;
    logic        dict1_write_enable = 1'b0;
    logic        dict2_write_enable = 1'b0;
    logic        dict3_write_enable = 1'b0;
    logic [6:0]  dict1_write_val = '0;
    logic [9:0]  dict2_write_val = '0;
    logic [14:0] dict3_write_val = '0;
    logic        debug_icache_miss, debug_comp_cache_miss;
    logic [31:0] debug_icache_occupancy, debug_comp_occupancy;
    logic        debug_compressible;
    logic        debug_field1_val_lookup_result;
    logic        debug_field2_val_lookup_result;
    logic        debug_field3_val_lookup_result;
    logic        debug_compressible_instr;
    logic [31:0] debug_decompressed_instr;

    int tests = 0;
    int fails = 0;

    logic        mem_hold = 1'b0;
    logic        rand_stall = 1'b0;
    logic        probe_en = 1'b0;
    logic [31:0] probe_word = '0;

    logic [31:0] sb [$];

    compressed_icache_controller #(
        .ICACHE_ENTRIES(16), .COMP_ENTRIES(32),
        .F1_VAL_W(7), .F2_VAL_W(10), .F3_VAL_W(15),
        .F1_KEY_W(3), .F2_KEY_W(5), .F3_KEY_W(8)
    ) dut (
        .clk(clk), .resetn(resetn),
        .proc_valid(proc_valid), .proc_ready(proc_ready),
        .proc_addr(proc_addr), .proc_rdata(proc_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata),
        .dict1_write_enable(dict1_write_enable),
        .dict2_write_enable(dict2_write_enable),
        .dict3_write_enable(dict3_write_enable),
        .dict1_write_val(dict1_write_val),
        .dict2_write_val(dict2_write_val),
        .dict3_write_val(dict3_write_val),
        .debug_icache_miss(debug_icache_miss),
        .debug_comp_cache_miss(debug_comp_cache_miss),
        .debug_icache_occupancy(debug_icache_occupancy),
        .debug_comp_occupancy(debug_comp_occupancy),
        .debug_compressible(debug_compressible),
        .debug_field1_val_lookup_result(debug_field1_val_lookup_result),
        .debug_field2_val_lookup_result(debug_field2_val_lookup_result),
        .debug_field3_val_lookup_result(debug_field3_val_lookup_result),
        .debug_compressible_instr(debug_compressible_instr),
        .debug_decompressed_instr(debug_decompressed_instr)
    );

    always #5 clk = ~clk;

    // Dictionary images. Entry 0 gives the 0x00000013 word. All other
    // entries are distinct and avoid the fields of the test words.
    function automatic logic [6:0] d1v(input int j);
        return (j == 0) ? 7'h13 : 7'(j);
    endfunction
    function automatic logic [9:0] d2v(input int j);
        return (j == 0) ? 10'h0 : 10'(j + 256);
    endfunction
    function automatic logic [14:0] d3v(input int j);
        return (j == 0) ? 15'h0 : 15'(j + 4096);
    endfunction

    // Memory image. Addresses with bit 3 and bit 6 clear hold words built
    // from dictionary entries, so they are compressible. Other addresses
    // have f3 = 0x7FFF, which no dictionary entry matches.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4)   return 32'hFFFF_FFFF;
        if (a == 32'h100) return 32'h0000_0093;
        if (!a[3] && !a[6])
            return {d3v(int'(a[15:8])), d2v(int'(a[11:7])), d1v(int'(a[6:4]))};
        return {15'h7FFF, a[16:0]};
    endfunction

    assign mem_req_rdata = probe_en ? probe_word : mem_word(mem_req_addr);

    always @(negedge clk) begin
        if (mem_hold)        mem_req_ready = 1'b0;
        else if (rand_stall) mem_req_ready = mem_req_valid && ($urandom_range(0, 2) != 0);
        else                 mem_req_ready = mem_req_valid;
    end

    int   miss_rises = 0;
    int   mem_reqs = 0;
    logic miss_q = 1'b0;
    always @(posedge clk) begin
        if (debug_icache_miss === 1'b1 && !miss_q) miss_rises <= miss_rises + 1;
        miss_q <= (debug_icache_miss === 1'b1);
        if (mem_req_valid === 1'b1 && mem_req_ready) mem_reqs <= mem_reqs + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One fetch. lat is the number of cycles from the edge that samples
    // proc_valid to the cycle in which proc_ready is seen.
    task automatic fetch(input logic [31:0] a, output int lat, output logic sm, output logic scm);
        logic [31:0] exp;
        @(negedge clk);
        proc_valid = 1'b1;
        proc_addr  = a;
        sb.push_back(mem_word(a));
        @(negedge clk);
        proc_valid = 1'b0;
        lat = 1;
        sm  = 1'b0;
        scm = 1'b0;
        forever begin
            sm  = sm  | debug_icache_miss;
            scm = scm | debug_comp_cache_miss;
            if (proc_ready || lat >= 60) break;
            @(negedge clk);
            lat++;
        end
        check("fetch_ready", 32'(proc_ready), 32'd1);
        exp = sb.pop_front();
        if (proc_ready) check("fetch_rdata", proc_rdata, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic sm, scm;
        int   base_miss, base_req, tb_misses;
        logic [31:0] a;

        // Reset state, with no dictionary strobes so the pointers clear.
        repeat (3) @(negedge clk);
        check("rst_proc_ready", 32'(proc_ready), 32'd0);
        check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        check("rst_imiss", 32'(debug_icache_miss), 32'd0);
        check("rst_cmiss", 32'(debug_comp_cache_miss), 32'd0);
        check("rst_comp_instr", 32'(debug_compressible_instr), 32'd0);
        check("rst_rdata", proc_rdata, 32'd0);
        check("rst_mem_addr", mem_req_addr, 32'd0);
        check("rst_decomp", debug_decompressed_instr, 32'd0);
        check("rst_ic_occ", debug_icache_occupancy, 32'd0);
        check("rst_cc_occ", debug_comp_occupancy, 32'd0);

        // Dictionary load under reset: 1000 strobes, so every pointer wraps.
        for (int i = 0; i < 1000; i++) begin
            dict1_write_enable = 1'b1;
            dict2_write_enable = 1'b1;
            dict3_write_enable = 1'b1;
            dict1_write_val = d1v(i % 8);
            dict2_write_val = d2v(i % 32);
            dict3_write_val = d3v(i % 256);
            @(negedge clk);
        end
        dict1_write_enable = 1'b0;
        dict2_write_enable = 1'b0;
        dict3_write_enable = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Compressible word at 0x0: combined miss, then a fill of the
        // compressed cache.
        fetch(32'h0, lat, sm, scm);
        check("c0_lat", 32'(lat), 32'd2);
        check("c0_imiss", 32'(sm), 32'd1);
        check("c0_cmiss", 32'(scm), 32'd1);
        check("c0_cc_occ", debug_comp_occupancy, 32'd1);
        check("c0_ic_occ", debug_icache_occupancy, 32'd0);
        check("c0_comp_instr", 32'(debug_compressible_instr), 32'd0);

        fetch(32'h0, lat, sm, scm);
        check("c0_hit_lat", 32'(lat), 32'd1);
        check("c0_hit_imiss", 32'(sm), 32'd0);
        check("c0_hit_cmiss", 32'(scm), 32'd0);
        check("c0_hit_comp_instr", 32'(debug_compressible_instr), 32'd1);
        check("c0_hit_decomp", debug_decompressed_instr, 32'h0000_0013);

        // Non-compressible word at 0x4: fill of the plain cache.
        fetch(32'h4, lat, sm, scm);
        check("p4_imiss", 32'(sm), 32'd1);
        check("p4_ic_occ", debug_icache_occupancy, 32'd1);
        check("p4_cc_occ", debug_comp_occupancy, 32'd1);
        fetch(32'h4, lat, sm, scm);
        check("p4_hit_lat", 32'(lat), 32'd1);
        check("p4_hit_imiss", 32'(sm), 32'd0);
        check("p4_hit_comp_instr", 32'(debug_compressible_instr), 32'd0);

        // Field lookups on words driven straight onto mem_req_rdata.
        probe_en = 1'b1;
        probe_word = 32'hFFFF_FFFF;
        #1;
        check("probe_ff_comp", 32'(debug_compressible), 32'd0);
        probe_word = 32'h0000_0093;
        #1;
        check("probe93_f1", 32'(debug_field1_val_lookup_result), 32'd1);
        check("probe93_f2", 32'(debug_field2_val_lookup_result), 32'd0);
        check("probe93_f3", 32'(debug_field3_val_lookup_result), 32'd1);
        check("probe93_comp", 32'(debug_compressible), 32'd0);
        probe_word = 32'h0000_0013;
        #1;
        check("probe13_comp", 32'(debug_compressible), 32'd1);
        probe_en = 1'b0;

        // Reset while the memory is stalled.
        mem_hold = 1'b1;
        @(negedge clk);
        proc_valid = 1'b1;
        proc_addr  = 32'h200;
        @(negedge clk);
        proc_valid = 1'b0;
        check("rw_req_valid", 32'(mem_req_valid), 32'd1);
        check("rw_miss_pulse", 32'(debug_icache_miss), 32'd1);
        check("rw_req_addr", mem_req_addr, 32'h200);
        @(negedge clk);
        check("rw_held", 32'(mem_req_valid), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("rw_drop_valid", 32'(mem_req_valid), 32'd0);
        check("rw_ic_occ", debug_icache_occupancy, 32'd0);
        check("rw_cc_occ", debug_comp_occupancy, 32'd0);
        resetn = 1'b1;
        mem_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("rw_idle_valid", 32'(mem_req_valid), 32'd0);
        check("rw_idle_ready", 32'(proc_ready), 32'd0);
        check("rw_idle_cc_occ", debug_comp_occupancy, 32'd0);

        // The dictionaries survive reset, so 0x0 is still compressible.
        fetch(32'h0, lat, sm, scm);
        check("rw_c0_miss", 32'(sm), 32'd1);
        check("rw_c0_cc_occ", debug_comp_occupancy, 32'd1);
        check("rw_c0_ic_occ", debug_icache_occupancy, 32'd0);
        fetch(32'h0, lat, sm, scm);
        check("rw_c0_comp_instr", 32'(debug_compressible_instr), 32'd1);
        check("rw_c0_decomp", debug_decompressed_instr, 32'h0000_0013);

        // Conflict: 0x4 and 0x44 share plain-cache index 1.
        fetch(32'h4, lat, sm, scm);
        check("cf1_miss", 32'(sm), 32'd1);
        check("cf1_occ", debug_icache_occupancy, 32'd1);
        fetch(32'h44, lat, sm, scm);
        check("cf2_miss", 32'(sm), 32'd1);
        check("cf2_occ", debug_icache_occupancy, 32'd1);
        fetch(32'h4, lat, sm, scm);
        check("cf3_miss", 32'(sm), 32'd1);
        check("cf3_cmiss", 32'(scm), 32'd1);
        check("cf3_occ", debug_icache_occupancy, 32'd1);

        // Statistics: 100 random fetches with a randomly stalling memory.
        @(negedge clk);
        base_miss = miss_rises;
        base_req  = mem_reqs;
        tb_misses = 0;
        rand_stall = 1'b1;
        for (int n = 0; n < 100; n++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            fetch(a, lat, sm, scm);
            check("stat_pulse_pair", 32'(sm), 32'(scm));
            if (sm) tb_misses++;
        end
        rand_stall = 1'b0;
        repeat (2) @(negedge clk);
        check("stat_pulses_vs_reqs", 32'(miss_rises - base_miss), 32'(mem_reqs - base_req));
        check("stat_seen_vs_reqs", 32'(tb_misses), 32'(mem_reqs - base_req));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
